// File: rtl/angle_move_ctrl.sv
// Point-to-point angular move sequencer: accepts a target angle, drives the motor the
// shorter way round until the encoder angle is within tolerance, then confirms a settle window.
module angle_move_ctrl #(
  parameter int TOL         = 2,
  parameter int SETTLE_CYC  = 1000,
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [8:0] cmd_angle,
  output logic       cmd_ready,
  input  logic [8:0] angle,
  input  logic       abort,
  output logic       motor_en,
  output logic       motor_dir,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [9:0]    TOL_V    = 10'(TOL);
  // Fault is taken on the edge where the timeout counter would reach TIMEOUT_CYC-1.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 2);
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_PLAN, S_RUN, S_SETTLE, S_DONE, S_FAULT} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [8:0]    r_target;
  logic [TW-1:0] r_tcnt;
  logic [SW-1:0] r_scnt;
  logic          r_motor_en;
  logic          r_motor_dir;
  logic          r_err;
  logic [1:0]    r_err_code;

  logic       w_accept;
  logic       w_illegal;
  logic       w_timeout;
  logic [9:0] w_t10;
  logic [9:0] w_a10;
  logic [9:0] w_diff;
  logic [9:0] w_dist;
  logic       w_pref;
  logic       w_in_tol;

  assign w_t10     = {1'b0, r_target};
  assign w_a10     = {1'b0, angle};
  assign w_diff    = (r_target >= angle) ? (w_t10 - w_a10) : (w_t10 + 10'd360 - w_a10);
  assign w_pref    = (w_diff <= 10'd180);
  assign w_dist    = w_pref ? w_diff : (10'd360 - w_diff);
  assign w_in_tol  = (w_dist <= TOL_V);

  assign cmd_ready = (r_state == S_IDLE) && !reset;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_illegal = (cmd_angle >= 9'd360);
  assign w_timeout = (r_tcnt == TMO_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept && !w_illegal) w_next = S_PLAN;
      S_PLAN, S_RUN, S_SETTLE: begin
        if (abort || w_timeout) begin
          w_next = S_FAULT;
        end else begin
          case (r_state)
            S_PLAN:   w_next = w_in_tol ? S_SETTLE : S_RUN;
            S_RUN: begin
              if (w_in_tol)                  w_next = S_SETTLE;
              else if (w_pref != r_motor_dir) w_next = S_PLAN;
            end
            default: begin
              if (!w_in_tol)               w_next = S_PLAN;
              else if (r_scnt == SET_LAST) w_next = S_DONE;
            end
          endcase
        end
      end
      S_DONE:   w_next = S_IDLE;
      S_FAULT:  w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_target    <= '0;
      r_tcnt      <= '0;
      r_scnt      <= '0;
      r_motor_en  <= 1'b0;
      r_motor_dir <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= 2'b00;
    end else begin
      r_state    <= w_next;
      r_motor_en <= (w_next == S_RUN);
      r_err      <= (w_next == S_FAULT) || (w_accept && w_illegal);

      if (r_state == S_PLAN && w_next == S_RUN)
        r_motor_dir <= w_pref;

      if (w_accept && !w_illegal) begin
        r_target   <= cmd_angle;
        r_tcnt     <= '0;
        r_err_code <= 2'b00;
      end else begin
        if (r_state != S_IDLE)
          r_tcnt <= r_tcnt + TW'(1);
        if (w_accept && w_illegal)
          r_err_code <= 2'b01;
        else if (w_next == S_FAULT)
          r_err_code <= abort ? 2'b11 : 2'b10;
      end

      if (w_next == S_SETTLE && r_state != S_SETTLE)
        r_scnt <= '0;
      else if (r_state == S_SETTLE)
        r_scnt <= r_scnt + SW'(1);
    end
  end

  assign motor_en  = r_motor_en;
  assign motor_dir = r_motor_dir;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign err       = r_err;
  assign err_code  = r_err_code;

endmodule
